mod_datapath: RTL
=================

Name: mod_datapath

Overview:
- Datapath half of the multi-cycle modulo unit. Holds the remainder and divisor registers, performs one unsigned repeated-subtraction step per cycle, and produces the completion flag `x` consumed by the modulo control FSM.
- Consumes `we` (subtract enable) and `s` (select/latch result) from that FSM.
- Presents the final remainder plus status to the ALU result mux.

Parameters:
- WIDTH, 32, operand/remainder width in bits (unsigned).
- CNT_W, 16, iteration counter width.
- MAX_ITER, 1000, iteration cap; used only when MOD_ITER_LIMIT_EN is defined. Must be < 2^CNT_W.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  capture operands, one-cycle pulse from issue logic, aligned with FSM START.
- a  in  WIDTH  dividend.
- b  in  WIDTH  divisor.
- we  in  1  subtract enable from control FSM.
- s  in  1  result-select from control FSM.
- x  out  1  done condition to control FSM (combinational from registers).
- result  out  WIDTH  latched remainder.
- result_valid  out  1  high while result is valid.
- div_by_zero  out  1  divisor was zero for current operation.
- iter_count  out  CNT_W  subtractions performed for current operation.
- iter_overflow  out  1  iteration cap hit; constant 0 when the feature is compiled out.

Behaviour:
- Reset: rem_q, div_q, result, iter_count = 0; result_valid, div_by_zero, iter_overflow = 0.
  - After reset div_q = 0, so x = 1 by definition.
- x = (rem_q < div_q) OR (div_q == 0) OR iter_overflow. Purely combinational from registers, no input dependence, so there is no loop through the FSM.
- Priority per cycle: reset > load > subtract > result latch.
- load = 1:
  - rem_q <= a; div_q <= b; iter_count <= 0.
  - result_valid <= 0; iter_overflow <= 0; div_by_zero <= (b == 0).
  - we and s are ignored that cycle.
- Subtract step, when we = 1 AND x = 0 AND load = 0:
  - rem_q <= rem_q - div_q (WIDTH bits, no borrow possible since rem_q >= div_q).
  - iter_count <= iter_count + 1, saturating at all-ones.
- Gating on x: we = 1 AND x = 1 leaves rem_q unchanged. This is required because the FSM still asserts we during the cycle it observes x and leaves SUBTRACT.
- Result latch, when s = 1 AND load = 0:
  - result <= rem_q; result_valid <= 1.
  - Held while s stays high. result_valid stays 1 until the next load or reset.
- Latency: quotient q = floor(a/b).
  - x rises q cycles after the first SUBTRACT cycle.
  - result_valid rises 1 cycle after the FSM enters RESULT.
- Boundary cases:
  - b = 0: x = 1 immediately, result = a, div_by_zero = 1.
  - a < b: zero subtractions, result = a.
  - a = b: one subtraction, result = 0.
  - Reset mid-operation aborts: all registers return to reset values; the FSM resets on the same edge.
  - load during SUBTRACT restarts with the new operands; the old remainder is discarded.

Optional Feature:
- Macro: MOD_ITER_LIMIT_EN.
- Defined:
  - When a subtract step would make iter_count == MAX_ITER, set iter_overflow <= 1 on that edge. This forces x = 1.
  - result is the partial remainder; iter_overflow is held until next load/reset.
  - Bounds worst-case latency for large a and small b.
- Undefined: no cap, iter_overflow tied to 0, MAX_ITER unused.

Decomposition:
- Shared package mod_pkg:
  - FSM state encodings START = 2'b00, SUBTRACT = 2'b01, RESULT = 2'b10.
  - Default WIDTH and CNT_W constants.
  - Typedef for the width-parameterised operand vector.
- One natural sub-module, mod_sub_cmp (combinational):
  - Inputs rem, div.
  - Outputs diff = rem - div and lt = (rem < div), using a single subtractor whose borrow-out gives lt.

Test Plan:
- a=17, b=5, load, then FSM runs → x rises after 3 we-cycles; result=2, iter_count=3, result_valid=1, div_by_zero=0.
- a=4, b=9 → x=1 on cycle after load, iter_count=0, result=4. we high with x=1 leaves rem_q=4.
- a=10, b=0 → div_by_zero=1, x=1, result=10, iter_count=0.
- a=100, b=7; assert reset after 5 subtractions → next cycle all outputs 0, x=1. Reload a=100, b=7 → result=2, iter_count=14.
- a=50, b=3, then load a=9, b=4 during SUBTRACT → result=1, iter_count=2; the old operation leaves no trace.
- With MOD_ITER_LIMIT_EN, MAX_ITER=1000, a=32'hFFFFFFFF, b=1 → iter_overflow=1 and x=1 at iter_count=1000; result=32'hFFFFFC17. Without the macro, iter_overflow stays 0.

Source files
------------

// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - shared constants and types for the modulo unit
// Contents:
//   START, SUBTRACT, RESULT  control FSM state encodings
//   DEFAULT_WIDTH            default operand/remainder width
//   DEFAULT_CNT_W            default iteration counter width
//   operand_t                operand vector at the default width
package mod_pkg;

  localparam logic [1:0] START    = 2'b00;
  localparam logic [1:0] SUBTRACT = 2'b01;
  localparam logic [1:0] RESULT   = 2'b10;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 16;

  typedef logic [DEFAULT_WIDTH-1:0] operand_t;

endpackage

// File: rtl/mod_sub_cmp.sv
// rtl/mod_sub_cmp.sv - combined subtractor and less-than compare
// Ports:
//   rem   in   WIDTH  minuend (current remainder)
//   div   in   WIDTH  subtrahend (divisor)
//   diff  out  WIDTH  rem - div, truncated to WIDTH bits
//   lt    out  1      rem < div, taken from the borrow-out
module mod_sub_cmp
  import mod_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] diff,
  output logic             lt
);

  // One WIDTH+1 bit subtraction: the extra top bit is the borrow, which is
  // set exactly when rem < div for unsigned operands.
  logic [WIDTH:0] wide_diff;

  assign wide_diff = {1'b0, rem} - {1'b0, div};
  assign diff      = wide_diff[WIDTH-1:0];
  assign lt        = wide_diff[WIDTH];

endmodule

// File: rtl/mod_datapath.sv
// rtl/mod_datapath.sv - remainder/divisor datapath of the multi-cycle modulo unit
// Ports:
//   CLK            in   1      clock, rising edge
//   reset          in   1      synchronous active-high reset
//   load           in   1      capture a/b and start a new operation
//   a              in   WIDTH  dividend
//   b              in   WIDTH  divisor
//   we             in   1      subtract enable from control FSM
//   s              in   1      latch result, from control FSM
//   x              out  1      done condition to control FSM
//   result         out  WIDTH  latched remainder
//   result_valid   out  1      result holds the current operation's remainder
//   div_by_zero    out  1      current divisor is zero
//   iter_count     out  CNT_W  subtractions done for current operation
//   iter_overflow  out  1      iteration cap reached
// Build option: MOD_ITER_LIMIT_EN enables the MAX_ITER iteration cap;
// without it iter_overflow is tied to 0 and MAX_ITER is unused.
module mod_datapath
  import mod_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CNT_W    = DEFAULT_CNT_W,
  parameter int MAX_ITER = 1000
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we,
  input  logic             s,
  output logic             x,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             div_by_zero,
  output logic [CNT_W-1:0] iter_count,
  output logic             iter_overflow
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] diff;
  logic             lt;
  logic             step;

  mod_sub_cmp #(.WIDTH(WIDTH)) u_sub_cmp (
    .rem  (rem_q),
    .div  (div_q),
    .diff (diff),
    .lt   (lt)
  );

  // Only registers feed x, so the FSM never sees a combinational loop.
  assign x    = lt | (div_q == '0) | iter_overflow;
  assign step = we & ~x;

`ifdef MOD_ITER_LIMIT_EN
  localparam logic [CNT_W-1:0] LAST_BEFORE_CAP = CNT_W'(MAX_ITER - 1);

  logic ovf_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (load) begin
      ovf_q <= 1'b0;
    end else if (step && (iter_count == LAST_BEFORE_CAP)) begin
      // This step brings the count to MAX_ITER; freezing here leaves the
      // partial remainder in rem_q.
      ovf_q <= 1'b1;
    end
  end

  assign iter_overflow = ovf_q;
`else
  assign iter_overflow = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      rem_q        <= '0;
      div_q        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      div_by_zero  <= 1'b0;
      iter_count   <= '0;
    end else if (load) begin
      rem_q        <= a;
      div_q        <= b;
      iter_count   <= '0;
      result_valid <= 1'b0;
      div_by_zero  <= (b == '0);
    end else begin
      if (step) begin
        rem_q <= diff;
        if (iter_count != '1) begin
          iter_count <= iter_count + 1'b1;
        end
      end
      if (s) begin
        result       <= rem_q;
        result_valid <= 1'b1;
      end
    end
  end

endmodule
